load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage between the execute stage and the load sign/zero-extension stage.
- Takes one load/store request of byte, half or word size and drives a word-organised data memory with byte enables.
- Misaligned accesses are split into two word transactions.
- Returns the raw loaded bytes right-aligned and zero-filled on rsp_rdata. The downstream extension stage consumes this value and applies the lb/lh/lw/lbu/lhu rules.

Parameters:
MISALIGN_EN, 1, 1 = misaligned requests are split into two accesses; 0 = misaligned requests return rsp_err with no memory access.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  qualifies rsp_valid: illegal size or disallowed misalignment
rsp_rdata  out  32  loaded bytes, right-aligned, upper bytes zero
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  32  word address, bits[1:0] = 0
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid; at least 1 cycle after gnt
mem_rdata  in  32  read data

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- req_ready is 1 only in IDLE. Accepting a request (req_valid && req_ready) registers we/size/addr/wdata.
- Transitions:
  - IDLE → REQ0 on accept.
  - IDLE → RESP directly with err=1 if size=11, or if the access is misaligned and MISALIGN_EN=0.
- Misaligned definition: half with addr[1:0]=3; word with addr[1:0]≠0. Bytes are never misaligned. Half at offset 1 stays within one word and is not split.
- REQ0: mem_req=1 with first-access fields, held stable until mem_gnt.
  - On gnt, a load → WAIT0.
  - On gnt, a store → REQ1 if split, else RESP.
- WAIT0: on mem_rvalid, capture data → REQ1 if split, else RESP.
- REQ1 / WAIT1: same as REQ0 / WAIT0 with second-access fields; the final step → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE. rsp_rdata/rsp_err update at entry to RESP and hold until the next response. Stores return rsp_rdata=0.
- First access (off = addr[1:0]):
  - mem_addr = {addr[31:2], 2'b00}
  - be: byte = 0001<<off; half = 0011<<off, truncated to 4 bits; word = 1111<<off, truncated.
  - mem_wdata = wdata << 8*off.
- Second access:
  - mem_addr = first + 4, wrapping mod 2^32 (0xFFFFFFFC+4 = 0).
  - be: half = 0001; word = (1<<off)−1.
  - mem_wdata = wdata >> 8*(4−off).
- Load assembly: (rdata0 >> 8*off) | (rdata1 << 8*(4−off)), only when split. Then mask to 8/16/32 bits by size.
- mem_we equals the registered req_we; mem_be=0 whenever mem_req=0.
- Minimum latency, aligned load with gnt immediate and rvalid one cycle later:
  - accept at edge 0
  - mem_req cycle 1
  - rvalid cycle 2
  - rsp_valid cycle 3
- Minimum latency, aligned store: rsp_valid in cycle 2.
- mem_rvalid outside WAIT0/WAIT1 is ignored. This includes a stale rvalid arriving after a mid-transaction reset.
- Reset mid-operation: all outputs return to reset values immediately. Any half-issued split store is abandoned.

Test Plan:
- Aligned lw at 0x100, mem_rdata=0xDEADBEEF, gnt immediate, rvalid 1 cycle later → one mem access, be=1111; rsp_valid in cycle 3, rsp_rdata=0xDEADBEEF, err=0.
- lb at 0x103, rdata=0x80FF0011 → be=1000, rsp_rdata=0x00000080. Same read as lh at 0x102 → be=1100, rsp_rdata=0x000080FF.
- sw 0x11223344 at 0x201 with gnt delayed 3 cycles → mem_req held stable; access 1 at 0x200 be=1110 wdata=0x22334400; access 2 at 0x204 be=0001 wdata=0x00000011; single rsp_valid pulse.
- lh at 0xFFFFFFFF, rdata0=0xAB000000, rdata1=0x000000CD → accesses at 0xFFFFFFFC then 0x00000000; rsp_rdata=0x0000CDAB.
- req_size=11, and separately MISALIGN_EN=0 with lw at 0x2 → no mem_req; rsp_valid=1 and rsp_err=1 one cycle after accept.
- reset asserted in WAIT0 of a load, then rvalid arrives → mem_req drops immediately, no rsp_valid, rvalid ignored, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between execute and load-extension stages: drives a word-organised
// data memory with byte enables and splits misaligned halves/words into two accesses.
module load_store_unit #(
   parameter logic MISALIGN_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic        split_q, split_d;
   logic [31:0] addr1_q, addr1_d;
   logic [3:0]  be1_q, be1_d;
   logic [31:0] wdata1_q, wdata1_d;
   logic [31:0] rdata0_q, rdata0_d;

   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic [3:0]  be_base;
   logic [7:0]  be_wide;
   logic [63:0] wdata_wide;
   logic        misaligned;
   logic        illegal;

   // Shifting into a double-width vector yields both accesses at once:
   // the low half is the first word, the high half spills into the next word.
   always_comb begin
      unique case (req_size)
         2'b00:   be_base = 4'b0001;
         2'b01:   be_base = 4'b0011;
         default: be_base = 4'b1111;
      endcase
      be_wide    = {4'b0000, be_base} << req_addr[1:0];
      wdata_wide = {32'h0000_0000, req_wdata} << {req_addr[1:0], 3'b000};
      misaligned = ((req_size == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
      illegal    = (req_size == 2'b11) || (misaligned && !MISALIGN_EN);
   end

   function automatic logic [31:0] assemble(input logic [31:0] hi, input logic [31:0] lo,
                                            input logic [1:0] off, input logic [1:0] size);
      logic [63:0] s;
      s = {hi, lo} >> {off, 3'b000};
      unique case (size)
         2'b00:   assemble = {24'h000000, s[7:0]};
         2'b01:   assemble = {16'h0000, s[15:0]};
         default: assemble = s[31:0];
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      off_d       = off_q;
      split_d     = split_q;
      addr1_d     = addr1_q;
      be1_d       = be1_q;
      wdata1_d    = wdata1_q;
      rdata0_d    = rdata0_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d        = req_we;
               size_d      = req_size;
               off_d       = req_addr[1:0];
               split_d     = misaligned;
               addr1_d     = {req_addr[31:2], 2'b00} + 32'd4;
               be1_d       = be_wide[7:4];
               wdata1_d    = wdata_wide[63:32];
               req_ready_d = 1'b0;
               if (illegal) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  state_d     = REQ0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_be_d    = be_wide[3:0];
                  mem_wdata_d = wdata_wide[31:0];
               end
            end
         end
         REQ0: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               mem_be_d  = '0;
               if (!we_q) begin
                  state_d = WAIT0;
               end else if (split_q) begin
                  state_d     = REQ1;
                  mem_req_d   = 1'b1;
                  mem_addr_d  = addr1_q;
                  mem_be_d    = be1_q;
                  mem_wdata_d = wdata1_q;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = '0;
               end
            end
         end
         WAIT0: begin
            if (mem_rvalid) begin
               rdata0_d = mem_rdata;
               if (split_q) begin
                  state_d     = REQ1;
                  mem_req_d   = 1'b1;
                  mem_addr_d  = addr1_q;
                  mem_be_d    = be1_q;
                  mem_wdata_d = wdata1_q;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = assemble(32'h0000_0000, mem_rdata, off_q, size_q);
               end
            end
         end
         REQ1: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               mem_be_d  = '0;
               if (!we_q) begin
                  state_d = WAIT1;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = '0;
               end
            end
         end
         WAIT1: begin
            if (mem_rvalid) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = assemble(mem_rdata, rdata0_q, off_q, size_q);
            end
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            mem_req_d   = 1'b0;
            mem_be_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         size_q      <= '0;
         off_q       <= '0;
         split_q     <= 1'b0;
         addr1_q     <= '0;
         be1_q       <= '0;
         wdata1_q    <= '0;
         rdata0_q    <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         off_q       <= off_d;
         split_q     <= split_d;
         addr1_q     <= addr1_d;
         be1_q       <= be1_d;
         wdata1_q    <= wdata1_d;
         rdata0_q    <= rdata0_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a
// byte-addressed reference memory; a second instance covers MISALIGN_EN=0.
module tb_load_store_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid, req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   logic        req_valid2;
   logic        req_ready2, rsp_valid2, rsp_err2;
   logic [31:0] rsp_rdata2;
   logic        mem_req2, mem_we2;
   logic [31:0] mem_addr2, mem_wdata2;
   logic [3:0]  mem_be2;

   load_store_unit #(.MISALIGN_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.MISALIGN_EN(1'b0)) dut2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid2), .rsp_err(rsp_err2), .rsp_rdata(rsp_rdata2),
      .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_be(mem_be2),
      .mem_wdata(mem_wdata2), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   // dmem is what the memory responder serves; rmem is the reference byte memory.
   logic [7:0] dmem [logic [31:0]];
   logic [7:0] rmem [logic [31:0]];

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction
   function automatic logic [7:0] dm_rd(input logic [31:0] a);
      return dmem.exists(a) ? dmem[a] : init_byte(a);
   endfunction
   function automatic logic [7:0] rm_rd(input logic [31:0] a);
      return rmem.exists(a) ? rmem[a] : init_byte(a);
   endfunction

   task automatic set_word(input logic [31:0] a, input logic [31:0] d);
      for (int i = 0; i < 4; i++) begin
         dmem[a + 32'(i)] = d[8*i +: 8];
         rmem[a + 32'(i)] = d[8*i +: 8];
      end
   endtask

   // Observations of the last transaction
   int          n_acc, n_rsp, rsp_cyc, first_req_cyc;
   logic [31:0] acc_addr [4];
   logic [3:0]  acc_be   [4];
   logic [31:0] acc_wd   [4];
   logic        acc_we   [4];
   logic        o_err;
   logic [31:0] o_rdata;
   bit          unstable, be_leak, timed_out, ready_before, ready_after;

   task automatic do_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt_dly, input int rv_dly);
      int waited, rv_at, cyc, after;
      bit rv_pend, holding;
      logic [31:0] rv_data, h_addr, h_wd;
      logic [3:0]  h_be;
      n_acc = 0; n_rsp = 0; rsp_cyc = -1; first_req_cyc = -1;
      unstable = 0; be_leak = 0; timed_out = 0; o_err = 1'b0; o_rdata = '0;
      waited = 0; rv_at = 0; after = -1; rv_pend = 0; holding = 0;
      rv_data = '0; h_addr = '0; h_wd = '0; h_be = '0;
      ready_before = req_ready;
      req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
      cyc = 1;
      forever begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (rsp_valid) begin
            n_rsp++; rsp_cyc = cyc; o_err = rsp_err; o_rdata = rsp_rdata;
            if (after < 0) after = 2;
         end
         if (mem_req) begin
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (holding && (mem_addr !== h_addr || mem_be !== h_be || mem_wdata !== h_wd))
               unstable = 1;
            if (!holding) begin
               holding = 1; waited = 0; h_addr = mem_addr; h_be = mem_be; h_wd = mem_wdata;
            end
            if (waited == gnt_dly) begin
               mem_gnt = 1'b1; holding = 0;
               if (n_acc < 4) begin
                  acc_addr[n_acc] = mem_addr; acc_be[n_acc] = mem_be;
                  acc_wd[n_acc] = mem_wdata; acc_we[n_acc] = mem_we;
               end
               n_acc++;
               if (mem_we) begin
                  for (int l = 0; l < 4; l++)
                     if (mem_be[l]) dmem[mem_addr + 32'(l)] = mem_wdata[8*l +: 8];
               end else begin
                  rv_pend = 1; rv_at = cyc + rv_dly;
                  rv_data = {dm_rd(mem_addr + 32'd3), dm_rd(mem_addr + 32'd2),
                             dm_rd(mem_addr + 32'd1), dm_rd(mem_addr)};
               end
            end else begin
               waited++;
            end
         end else if (mem_be !== 4'b0000) begin
            be_leak = 1;
         end
         if (rv_pend && cyc == rv_at) begin
            mem_rvalid = 1'b1; mem_rdata = rv_data; rv_pend = 0;
         end
         if (after == 0) break;
         if (after > 0) after--;
         if (cyc > 200) begin timed_out = 1; break; end
         @(posedge clk); #1; cyc++;
      end
      ready_after = req_ready;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req_valid = 1'b0; req_valid2 = 1'b0; req_we = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got ready/rv/err/req/we=%b, want 10000",
                  {req_ready, rsp_valid, rsp_err, mem_req, mem_we});
      end
      checks++;
      if ({rsp_rdata, mem_addr, mem_be, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_data: got rdata=%h addr=%h be=%b wdata=%h, want all zero",
                  rsp_rdata, mem_addr, mem_be, mem_wdata);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: got ready=%b req=%b, want 1 0", req_ready, mem_req);
      end
   endtask

   task automatic test_aligned_lw;
      set_word(32'h100, 32'hDEADBEEF);
      do_txn(1'b0, 2'b10, 32'h100, 32'h0, 0, 1);
      checks++;
      if (n_acc !== 1 || acc_addr[0] !== 32'h100 || acc_be[0] !== 4'b1111 || acc_we[0] !== 1'b0) begin
         errors++;
         $display("FAIL lw_access: got n=%0d addr=%h be=%b we=%b, want 1 00000100 1111 0",
                  n_acc, acc_addr[0], acc_be[0], acc_we[0]);
      end
      checks++;
      if (first_req_cyc !== 1 || rsp_cyc !== 3) begin
         errors++;
         $display("FAIL lw_latency: got req_cyc=%0d rsp_cyc=%0d, want 1 3", first_req_cyc, rsp_cyc);
      end
      checks++;
      if (n_rsp !== 1 || o_err !== 1'b0 || o_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL lw_resp: got pulses=%0d err=%b rdata=%h, want 1 0 deadbeef", n_rsp, o_err, o_rdata);
      end
   endtask

   task automatic test_byte_half;
      set_word(32'h100, 32'h80FF0011);
      do_txn(1'b0, 2'b00, 32'h103, 32'h0, 1, 2);
      checks++;
      if (n_acc !== 1 || acc_be[0] !== 4'b1000 || o_rdata !== 32'h00000080) begin
         errors++;
         $display("FAIL lb_103: got n=%0d be=%b rdata=%h, want 1 1000 00000080", n_acc, acc_be[0], o_rdata);
      end
      do_txn(1'b0, 2'b01, 32'h102, 32'h0, 0, 1);
      checks++;
      if (n_acc !== 1 || acc_be[0] !== 4'b1100 || o_rdata !== 32'h000080FF) begin
         errors++;
         $display("FAIL lh_102: got n=%0d be=%b rdata=%h, want 1 1100 000080ff", n_acc, acc_be[0], o_rdata);
      end
   endtask

   task automatic test_split_store;
      do_txn(1'b1, 2'b10, 32'h201, 32'h11223344, 3, 1);
      checks++;
      if (n_acc !== 2 || acc_addr[0] !== 32'h200 || acc_be[0] !== 4'b1110 || acc_wd[0] !== 32'h22334400) begin
         errors++;
         $display("FAIL sw_acc0: got n=%0d addr=%h be=%b wd=%h, want 2 00000200 1110 22334400",
                  n_acc, acc_addr[0], acc_be[0], acc_wd[0]);
      end
      checks++;
      if (acc_addr[1] !== 32'h204 || acc_be[1] !== 4'b0001 || acc_wd[1] !== 32'h00000011 || acc_we[1] !== 1'b1) begin
         errors++;
         $display("FAIL sw_acc1: got addr=%h be=%b wd=%h we=%b, want 00000204 0001 00000011 1",
                  acc_addr[1], acc_be[1], acc_wd[1], acc_we[1]);
      end
      checks++;
      if (unstable || be_leak || n_rsp !== 1 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
         errors++;
         $display("FAIL sw_resp: got unstable=%0d be_leak=%0d pulses=%0d err=%b rdata=%h, want 0 0 1 0 0",
                  unstable, be_leak, n_rsp, o_err, o_rdata);
      end
   endtask

   task automatic test_wrap_load;
      set_word(32'hFFFFFFFC, 32'hAB000000);
      set_word(32'h00000000, 32'h000000CD);
      do_txn(1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, 0, 1);
      checks++;
      if (n_acc !== 2 || acc_addr[0] !== 32'hFFFFFFFC || acc_addr[1] !== 32'h0 ||
          acc_be[0] !== 4'b1000 || acc_be[1] !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_acc: got n=%0d a0=%h a1=%h be0=%b be1=%b, want 2 fffffffc 00000000 1000 0001",
                  n_acc, acc_addr[0], acc_addr[1], acc_be[0], acc_be[1]);
      end
      checks++;
      if (o_rdata !== 32'h0000CDAB || o_err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_rdata: got %h err=%b, want 0000cdab 0", o_rdata, o_err);
      end
   endtask

   task automatic test_illegal_size;
      do_txn(1'b0, 2'b11, 32'h100, 32'h0, 0, 1);
      checks++;
      if (n_acc !== 0 || first_req_cyc !== -1 || rsp_cyc !== 1 || o_err !== 1'b1 || n_rsp !== 1) begin
         errors++;
         $display("FAIL illegal_size: got acc=%0d req_cyc=%0d rsp_cyc=%0d err=%b pulses=%0d, want 0 -1 1 1 1",
                  n_acc, first_req_cyc, rsp_cyc, o_err, n_rsp);
      end
   endtask

   task automatic test_no_misalign;
      bit saw_req;
      logic [31:0] d;
      saw_req = 0;
      req_we = 1'b0; req_size = 2'b10; req_addr = 32'h2; req_valid2 = 1'b1;
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      checks++;
      if (rsp_valid2 !== 1'b1 || rsp_err2 !== 1'b1 || mem_req2 !== 1'b0) begin
         errors++;
         $display("FAIL nomis_err: got rv=%b err=%b req=%b, want 1 1 0", rsp_valid2, rsp_err2, mem_req2);
      end
      repeat (3) begin
         @(posedge clk); #1;
         if (mem_req2) saw_req = 1;
      end
      checks++;
      if (saw_req || rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1) begin
         errors++;
         $display("FAIL nomis_idle: got saw_req=%0d rv=%b ready=%b, want 0 0 1", saw_req, rsp_valid2, req_ready2);
      end
      // Half at offset 1 stays in one word, so it is legal even without splitting
      d = $urandom;
      req_size = 2'b01; req_addr = 32'h1; req_valid2 = 1'b1;
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      checks++;
      if (mem_req2 !== 1'b1 || mem_be2 !== 4'b0110 || mem_addr2 !== 32'h0) begin
         errors++;
         $display("FAIL nomis_lh1_req: got req=%b be=%b addr=%h, want 1 0110 00000000", mem_req2, mem_be2, mem_addr2);
      end
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      checks++;
      if (rsp_valid2 !== 1'b1 || rsp_err2 !== 1'b0 || rsp_rdata2 !== {16'h0, d[23:8]}) begin
         errors++;
         $display("FAIL nomis_lh1_resp: got rv=%b err=%b rdata=%h, want 1 0 %h",
                  rsp_valid2, rsp_err2, rsp_rdata2, {16'h0, d[23:8]});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midop;
      bit saw;
      saw = 0;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h300;
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_gnt = mem_req;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      reset = 1'b1;
      #2;
      checks++;
      if (mem_req !== 1'b0 || mem_be !== 4'b0000 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL midop_reset: got req=%b be=%b ready=%b rv=%b, want 0 0000 1 0",
                  mem_req, mem_be, req_ready, rsp_valid);
      end
      #2 reset = 1'b0;
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      repeat (4) begin
         if (rsp_valid || mem_req || !req_ready) saw = 1;
         @(posedge clk); #1;
      end
      checks++;
      if (saw) begin
         errors++;
         $display("FAIL midop_stale_rvalid: got activity=1 after reset, want 0");
      end
   endtask

   task automatic test_store_then_load;
      do_txn(1'b1, 2'b10, 32'h400, 32'hA5A55A5A, 0, 1);
      checks++;
      if (rsp_cyc !== 2 || n_acc !== 1 || acc_be[0] !== 4'b1111) begin
         errors++;
         $display("FAIL sw_latency: got rsp_cyc=%0d n=%0d be=%b, want 2 1 1111", rsp_cyc, n_acc, acc_be[0]);
      end
      do_txn(1'b0, 2'b10, 32'h400, 32'h0, 0, 1);
      checks++;
      if (o_rdata !== 32'hA5A55A5A) begin
         errors++;
         $display("FAIL sw_readback: got %h, want a5a55a5a", o_rdata);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 60; it++) begin
         logic        we;
         logic [1:0]  size;
         logic [31:0] addr, wdata, w0, b, exp_rd;
         logic [3:0]  ebe [2];
         logic [31:0] ewd [2], emask [2];
         int          nb, r, n_exp, k;
         bit          exp_err;
         r = $urandom_range(0, 7);
         size = (r == 7) ? 2'b11 : 2'(r % 3);
         we = 1'($urandom);
         if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFFC;
         else addr = 32'h1000 + 32'(4 * $urandom_range(0, 15));
         addr = addr + 32'($urandom_range(0, 3));
         wdata = $urandom;
         nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
         exp_err = (size == 2'b11);
         w0 = addr & 32'hFFFFFFFC;
         n_exp = 1;
         exp_rd = '0;
         for (int j = 0; j < 2; j++) begin ebe[j] = '0; ewd[j] = '0; emask[j] = '0; end
         if (!exp_err) begin
            for (int i = 0; i < nb; i++) begin
               b = addr + 32'(i);
               k = ((b & 32'hFFFFFFFC) == w0) ? 0 : 1;
               if (k == 1) n_exp = 2;
               ebe[k][b[1:0]] = 1'b1;
               ewd[k][8*b[1:0] +: 8] = wdata[8*i +: 8];
               emask[k][8*b[1:0] +: 8] = 8'hFF;
               exp_rd[8*i +: 8] = rm_rd(b);
               if (we) rmem[b] = wdata[8*i +: 8];
            end
            if (we) exp_rd = '0;
         end
         do_txn(we, size, addr, wdata, $urandom_range(0, 3), $urandom_range(1, 3));
         checks++;
         if (timed_out || n_rsp !== 1 || !ready_before || !ready_after || unstable || be_leak) begin
            errors++;
            $display("FAIL rnd%0d_handshake: got timeout=%0d pulses=%0d rdy=%0d/%0d unstable=%0d be_leak=%0d, want 0 1 1/1 0 0",
                     it, timed_out, n_rsp, ready_before, ready_after, unstable, be_leak);
         end
         checks++;
         if (o_err !== exp_err || n_acc !== (exp_err ? 0 : n_exp)) begin
            errors++;
            $display("FAIL rnd%0d_err: got err=%b accesses=%0d, want %b %0d",
                     it, o_err, n_acc, exp_err, exp_err ? 0 : n_exp);
         end
         if (!exp_err && n_acc == n_exp) begin
            for (int j = 0; j < n_exp; j++) begin
               checks++;
               if (acc_addr[j] !== w0 + 32'(4 * j) || acc_be[j] !== ebe[j] || acc_we[j] !== we ||
                   (we && ((acc_wd[j] & emask[j]) !== ewd[j]))) begin
                  errors++;
                  $display("FAIL rnd%0d_acc%0d: got addr=%h be=%b we=%b wd=%h, want %h %b %b %h (lanes %h)",
                           it, j, acc_addr[j], acc_be[j], acc_we[j], acc_wd[j] & emask[j],
                           w0 + 32'(4 * j), ebe[j], we, ewd[j], emask[j]);
               end
            end
            checks++;
            if (o_rdata !== exp_rd) begin
               errors++;
               $display("FAIL rnd%0d_rdata: we=%b size=%0d addr=%h got %h, want %h",
                        it, we, size, addr, o_rdata, exp_rd);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_aligned_lw();
      test_byte_half();
      test_split_store();
      test_wrap_load();
      test_illegal_size();
      test_no_misalign();
      test_reset_midop();
      test_store_then_load();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
